// File: rtl/divider_unit_pkg.sv
// Shared definitions for the EX-stage divider: FSM encoding, iteration count, and the
// function codes that upstream decode maps onto start/signed_div.
package divider_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
        DIV_DIVZERO = 2'b01,
        DIV_RUN     = 2'b10,
        DIV_DONE    = 2'b11
    } div_state_e;

    localparam int DIV_CYCLES = 32;

    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/divider_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the
// divisor, keep the difference when there is no borrow.
module divider_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor, so the shifted value is below 2*divisor and the kept result fits WIDTH bits.
    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/divider_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU); result_div = {remainder, quotient}.
// Stalls the pipeline via busy and aborts on cancel.
module divider_unit
    import divider_unit_pkg::*;
#(
    parameter int WIDTH    = DIV_CYCLES,
    parameter int CNT_BITS = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   operand_1,
    input  logic [WIDTH-1:0]   operand_2,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result_div
);

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

    div_state_e           state_q, state_d;
    logic [CNT_BITS-1:0]  counter_q, counter_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     op1_abs, op2_abs;
    logic [WIDTH-1:0]     step_rem, quo_raw;
    logic                 step_q;

    assign op1_abs = (signed_div && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
    assign op2_abs = (signed_div && operand_2[WIDTH-1]) ? -operand_2 : operand_2;

    divider_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem_in       (rem_q),
        .dividend_bit (dvd_q[WIDTH-1]),
        .divisor      (dvs_q),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // The dividend register doubles as the quotient shift register.
    assign quo_raw = {dvd_q[WIDTH-2:0], step_q};

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        counter_d = counter_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            DIV_IDLE: begin
                if (start && !cancel) begin
                    neg_quo_d = signed_div & (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
                    neg_rem_d = signed_div & operand_1[WIDTH-1];
                    dvs_d     = op2_abs;
                    rem_d     = '0;
                    counter_d = '0;
                    if (operand_2 == '0) begin
                        dvd_d   = operand_1;
                        state_d = DIV_DIVZERO;
                    end else begin
                        dvd_d   = op1_abs;
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_DIVZERO: begin
                if (cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    result_d = {dvd_q, {WIDTH{1'b1}}};
                    done_d   = 1'b1;
                    state_d  = DIV_DONE;
                end
            end
            DIV_RUN: begin
                if (cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d     = step_rem;
                    dvd_d     = quo_raw;
                    counter_d = counter_q + CNT_BITS'(1);
                    if (counter_q == LAST_CNT) begin
                        result_d = {neg_rem_q ? -step_rem : step_rem,
                                    neg_quo_q ? -quo_raw  : quo_raw};
                        done_d   = 1'b1;
                        state_d  = DIV_DONE;
                    end
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: datapath latches are reset along with control so nothing stale survives a reset.
        if (!rst) begin
            state_q   <= DIV_IDLE;
            counter_q <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            counter_q <= counter_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    // Combinational so the ID/EX stall asserts in the issue cycle itself.
    assign busy       = (state_q == DIV_RUN) ||
                        ((state_q == DIV_IDLE) && start && !cancel);
    assign done       = done_q;
    assign result_div = result_q;

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_divider_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   operand_1;
    logic [W-1:0]   operand_2;
    logic           cancel;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result_div;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*W-1:0] last_exp;

    divider_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .result_div (result_div)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division; SV truncates toward zero and % follows the dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Issue one op, measure latency and busy cycles, check result and single done pulse.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp, input bit cancel_in_done, input string tag);
        int edges;
        int busy_cnt;
        @(negedge clk);
        operand_1  = a;
        operand_2  = b;
        signed_div = sgn;
        start      = 1'b1;
        #1;
        busy_cnt = int'(busy);
        edges    = 0;
        while (edges < 60 && !done) begin
            @(negedge clk);
            start = 1'b0;
            edges++;
            if (busy) busy_cnt++;
        end
        check({tag, " latency"}, 64'(edges), (b == 0) ? 64'd2 : 64'd33);
        check({tag, " result"}, result_div, exp);
        if (b != 0) check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        if (cancel_in_done) cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        check({tag, " held"}, result_div, exp);
        last_exp = exp;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int n_done;
        int edges;
        logic [31:0] a, b;
        logic        sgn;

        rst = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0;
        operand_1 = '0; operand_2 = '0; last_exp = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", result_div, 64'd0);
        rst = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0, "udiv_100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, "sdiv_m7_2");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, 1'b0, "udiv_m7_2");
        run_op(32'h0000_1234, 32'd0, 1'b0, {32'h0000_1234, 32'hFFFF_FFFF}, 1'b0, "divzero");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 1'b0, "overflow");
        run_op(32'd77, 32'hFFFF_FFF6, 1'b1, {32'd7, 32'hFFFF_FFF9}, 1'b1, "cancel_in_done");

        // Cancel mid-run: back to IDLE, no done, result untouched.
        @(negedge clk);
        operand_1 = 32'h0005_5555; operand_2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        count_dones(40, n_done);
        check("cancel no_done", 64'(n_done), 64'd0);
        check("cancel result_kept", result_div, last_exp);
        run_op(32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, 1'b0, "after_cancel");

        // Cancel beats start in IDLE.
        @(negedge clk);
        operand_1 = 32'd50; operand_2 = 32'd5; start = 1'b1; cancel = 1'b1;
        #1;
        check("cancel_beats_start busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        count_dones(40, n_done);
        check("cancel_beats_start no_done", 64'(n_done), 64'd0);

        // Start held through RUN with operands changing: one done, original operands used.
        @(negedge clk);
        operand_1 = 32'd1000; operand_2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        edges = 0;
        while (edges < 60 && !done) begin
            @(negedge clk);
            edges++;
            if (edges == 5) begin
                operand_1 = 32'hDEAD_BEEF; operand_2 = 32'd9;
            end
        end
        start = 1'b0;
        check("held_start latency", 64'(edges), 64'd33);
        check("held_start result", result_div, {32'd1, 32'd333});
        count_dones(40, n_done);
        check("held_start single_done", 64'(n_done), 64'd0);
        last_exp = {32'd1, 32'd333};

        // Reset mid-run.
        @(negedge clk);
        operand_1 = 32'h00FF_FFFF; operand_2 = 32'd17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrun_reset busy", 64'(busy), 64'd0);
        check("midrun_reset done", 64'(done), 64'd0);
        check("midrun_reset result", result_div, 64'd0);
        count_dones(40, n_done);
        check("midrun_reset no_done", 64'(n_done), 64'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 15);
                3:       b = -($urandom_range(1, 15));
                4: begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
                default: b = $urandom;
            endcase
            run_op(a, b, sgn, ref_div(a, b, sgn), bit'($urandom_range(0, 1)),
                   $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
